// File: rtl/bp_pkg.sv
// bp_pkg: shared types and saturating-counter helpers for the branch predictor slice.
package bp_pkg;

    typedef enum logic {INIT, RUN} state_e;

    // Weakly not-taken starting value: 2^(bits-1)-1.
    function automatic int ctr_init(int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sat_inc(int c, int bits);
        return (c >= (1 << bits) - 1) ? c : c + 1;
    endfunction

    function automatic int sat_dec(int c);
        return (c <= 0) ? 0 : c - 1;
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_update.sv
// sat_counter_update: next value of a saturating counter given the resolved outcome.
module sat_counter_update
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    assign ctr_o = CTR_BITS'(taken_i ? sat_inc(int'(ctr_i), CTR_BITS) : sat_dec(int'(ctr_i)));

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT of saturating counters indexed by PC or PC^GHR, with
// a registered lookup port, an update port and a power-up INIT sweep of the table.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 8,
    parameter int GSHARE     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  ready,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    output logic [31:0]           mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(ctr_init(CTR_BITS));

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [HIST_BITS-1:0]    ghr_q, ghr_d;
    logic                    pred_valid_q, pred_valid_d;
    logic                    pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0]   pred_index_q, pred_index_d;
    logic [31:0]             mcnt_q, mcnt_d;
    logic [CTR_BITS-1:0]     pht_q [ENTRIES];

    logic                    init_we, lk_fire, upd_fire;
    logic [INDEX_BITS-1:0]   pc_idx, lk_idx;
    logic [CTR_BITS-1:0]     upd_nxt, lk_ctr;
    logic                    unused_pc;

    assign unused_pc = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end

    always_comb begin
        state_d = (state_q == INIT && ptr_q == '1) ? RUN : state_q;
        ptr_d   = (state_q == INIT) ? ptr_q + 1'b1 : ptr_q;
    end

    always_comb begin
        ready   = (state_q == RUN);
        init_we = (state_q == INIT);
    end

    assign lk_fire  = ready & lookup_valid;
    assign upd_fire = ready & upd_valid;
    assign pc_idx   = lookup_pc[INDEX_BITS+1:2];
    assign lk_idx   = (GSHARE != 0) ? pc_idx ^ INDEX_BITS'(ghr_q) : pc_idx;

    sat_counter_update #(.CTR_BITS(CTR_BITS)) u_upd (
        .ctr_i   (pht_q[upd_index]),
        .taken_i (upd_taken),
        .ctr_o   (upd_nxt)
    );

    // Write-first: a same-cycle update to the looked-up entry is visible to the lookup.
    assign lk_ctr = (upd_fire && upd_index == lk_idx) ? upd_nxt : pht_q[lk_idx];

    always_ff @(posedge CLK)
        if (init_we)
            pht_q[ptr_q] <= INIT_VAL;
        else if (upd_fire)
            pht_q[upd_index] <= upd_nxt;

    always_comb begin
        ghr_d        = upd_fire ? HIST_BITS'({ghr_q, upd_taken}) : ghr_q;
        mcnt_d       = (upd_fire && upd_mispredict && mcnt_q != '1) ? mcnt_q + 32'd1 : mcnt_q;
        pred_valid_d = lk_fire;
        pred_taken_d = lk_fire ? lk_ctr[CTR_BITS-1] : pred_taken_q;
        pred_index_d = lk_fire ? lk_idx : pred_index_q;
    end

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            ghr_q        <= '0;
            mcnt_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            ghr_q        <= ghr_d;
            mcnt_q       <= mcnt_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_index       = pred_index_q;
    assign mispredict_count = mcnt_q;

endmodule
